// File: rtl/argmax_classifier.sv
// Sequential argmax over ten signed output-layer scores: captures a frame, scans
// one class per cycle, and presents winner index, maximum and top-two margin.
module argmax_classifier #(
    parameter int N_CLASSES = 10,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] score0,
    input  logic [DATA_W-1:0] score1,
    input  logic [DATA_W-1:0] score2,
    input  logic [DATA_W-1:0] score3,
    input  logic [DATA_W-1:0] score4,
    input  logic [DATA_W-1:0] score5,
    input  logic [DATA_W-1:0] score6,
    input  logic [DATA_W-1:0] score7,
    input  logic [DATA_W-1:0] score8,
    input  logic [DATA_W-1:0] score9,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        class_idx,
    output logic [DATA_W-1:0] max_score,
    output logic [DATA_W-1:0] margin,
    output logic [15:0]       frame_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [3:0] LAST = 4'(N_CLASSES - 1);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state;
    logic signed [DATA_W-1:0] cap [0:9];
    logic signed [DATA_W-1:0] best, second;
    logic [3:0] idx, cnt;

    logic signed [DATA_W-1:0] cur, nbest, nsecond;
    logic [3:0]  nidx;
    logic [DATA_W:0] diff;

    // Next-step comparison is shared by the running update and the final
    // cycle, so the result registers see the last class without an extra cycle.
    always_comb begin
        cur     = cap[cnt];
        nbest   = best;
        nsecond = second;
        nidx    = idx;
        if (cur > best) begin
            nsecond = best;
            nbest   = cur;
            nidx    = cnt;
        end else if (cur > second) begin
            nsecond = cur;
        end
        diff = {nbest[DATA_W-1], nbest} - {nsecond[DATA_W-1], nsecond};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            class_idx   <= '0;
            max_score   <= '0;
            margin      <= '0;
            frame_count <= '0;
            best        <= '0;
            second      <= '0;
            idx         <= '0;
            cnt         <= '0;
            for (int unsigned i = 0; i < 10; i++) cap[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cap[0]   <= score0;
                        cap[1]   <= score1;
                        cap[2]   <= score2;
                        cap[3]   <= score3;
                        cap[4]   <= score4;
                        cap[5]   <= score5;
                        cap[6]   <= score6;
                        cap[7]   <= score7;
                        cap[8]   <= score8;
                        cap[9]   <= score9;
                        best     <= score0;
                        second   <= MOST_NEG;
                        idx      <= '0;
                        cnt      <= 4'd1;
                        in_ready <= 1'b0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    best   <= nbest;
                    second <= nsecond;
                    idx    <= nidx;
                    cnt    <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        class_idx <= nidx;
                        max_score <= nbest;
                        margin    <= diff[DATA_W-1:0];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        in_ready    <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed checks for argmax_classifier: latency, ties, extremes, stalls,
// mid-scan reset, input capture and back-to-back frames.
module tb_argmax_classifier;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sc [0:9];
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  class_idx;
    logic [15:0] max_score;
    logic [15:0] margin;
    logic [15:0] frame_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    argmax_classifier #(.N_CLASSES(10), .DATA_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .score0(sc[0]), .score1(sc[1]), .score2(sc[2]), .score3(sc[3]), .score4(sc[4]),
        .score5(sc[5]), .score6(sc[6]), .score7(sc[7]), .score8(sc[8]), .score9(sc[9]),
        .out_valid(out_valid), .out_ready(out_ready), .class_idx(class_idx),
        .max_score(max_score), .margin(margin), .frame_count(frame_count)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int v[10]);
        for (int j = 0; j < 10; j++) sc[j] = 16'(v[j]);
    endtask

    task automatic test_reset;
        in_valid = 1'b1;
        out_ready = 1'b1;
        load('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
        reset = 1'b1;
        tick(2);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
        vectors++;
        if (class_idx !== 4'd0 || max_score !== 16'd0 || margin !== 16'd0 || frame_count !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_vals: idx=%0d max=%0d margin=%0d fc=%0d expected all 0",
                     class_idx, max_score, margin, frame_count);
        end
        in_valid = 1'b0;
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_basic;
        load('{5, -3, 100, 7, 100, 0, -1, 2, 99, -32768});
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick(1);
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_accept: in_ready=%b expected 0", in_ready);
        end
        tick(8);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_early: out_valid=%b expected 0 after 8 edges", out_valid);
        end
        tick(1);
        vectors++;
        if (out_valid !== 1'b1 || class_idx !== 4'd2 || max_score !== 16'd100 || margin !== 16'd0) begin
            miscompares++;
            $display("FAIL basic_result: v=%b idx=%0d max=%0d margin=%0d expected 1 2 100 0",
                     out_valid, class_idx, max_score, margin);
        end
        tick(1);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_count !== 16'd1) begin
            miscompares++;
            $display("FAIL basic_handshake: v=%b rdy=%b fc=%0d expected 0 1 1",
                     out_valid, in_ready, frame_count);
        end
    endtask

    task automatic test_extreme;
        load('{-32768, -32768, -32768, -32768, -32768, -32768, -32768, 32767, -32768, -32768});
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(9);
        vectors++;
        if (out_valid !== 1'b1 || class_idx !== 4'd7 || max_score !== 16'h7FFF || margin !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL extreme_result: v=%b idx=%0d max=%h margin=%h expected 1 7 7fff ffff",
                     out_valid, class_idx, max_score, margin);
        end
        out_ready = 1'b1;
        tick(1);
        vectors++;
        if (frame_count !== 16'd2) begin
            miscompares++;
            $display("FAIL extreme_fc: fc=%0d expected 2", frame_count);
        end
    endtask

    task automatic test_stall;
        int bad = 0;
        load('{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(9);
        vectors++;
        if (out_valid !== 1'b1 || class_idx !== 4'd9 || max_score !== 16'd10 || margin !== 16'd1) begin
            miscompares++;
            $display("FAIL stall_result: v=%b idx=%0d max=%0d margin=%0d expected 1 9 10 1",
                     out_valid, class_idx, max_score, margin);
        end
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            for (int j = 0; j < 10; j++) sc[j] = 16'(1000 + c * 10 + j);
            tick(1);
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || class_idx !== 4'd9 ||
                max_score !== 16'd10 || margin !== 16'd1 || frame_count !== 16'd2) begin
                miscompares++;
                $display("FAIL stall_hold: cyc %0d v=%b rdy=%b idx=%0d max=%0d margin=%0d fc=%0d expected 1 0 9 10 1 2",
                         c, out_valid, in_ready, class_idx, max_score, margin, frame_count);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick(1);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_count !== 16'd3) begin
            miscompares++;
            $display("FAIL stall_release: v=%b rdy=%b fc=%0d expected 0 1 3", out_valid, in_ready, frame_count);
        end
        tick(3);
        vectors++;
        if (frame_count !== 16'd3 || class_idx !== 4'd9 || max_score !== 16'd10 || margin !== 16'd1) begin
            miscompares++;
            $display("FAIL idle_retain: fc=%0d idx=%0d max=%0d margin=%0d expected 3 9 10 1",
                     frame_count, class_idx, max_score, margin);
        end
        bad = 0;
    endtask

    task automatic test_reset_mid;
        int seen = 0;
        load('{7, 8, 9, 10, 11, 12, 13, 14, 15, 16});
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(4);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || frame_count !== 16'd0 || class_idx !== 4'd0) begin
            miscompares++;
            $display("FAIL midreset_state: rdy=%b v=%b fc=%0d idx=%0d expected 1 0 0 0",
                     in_ready, out_valid, frame_count, class_idx);
        end
        for (int c = 0; c < 12; c++) begin
            tick(1);
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin
            miscompares++;
            $display("FAIL midreset_noemit: out_valid high %0d cycles expected 0", seen);
        end
        load('{-5, -4, -3, -2, -1, -6, -7, -8, -9, -10});
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(9);
        vectors++;
        if (out_valid !== 1'b1 || class_idx !== 4'd4 || max_score !== 16'hFFFF || margin !== 16'd1) begin
            miscompares++;
            $display("FAIL midreset_next: v=%b idx=%0d max=%h margin=%0d expected 1 4 ffff 1",
                     out_valid, class_idx, max_score, margin);
        end
        tick(1);
        vectors++;
        if (frame_count !== 16'd1) begin
            miscompares++;
            $display("FAIL midreset_fc: fc=%0d expected 1", frame_count);
        end
    endtask

    task automatic test_capture;
        load('{3, 1, 4, 1, 5, 9, 2, 6, 5, 3});
        out_ready = 1'b1;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            for (int j = 0; j < 10; j++) sc[j] = 16'(20000 + c * 100 + j * 7);
            tick(1);
        end
        vectors++;
        if (out_valid !== 1'b1 || class_idx !== 4'd5 || max_score !== 16'd9 || margin !== 16'd3) begin
            miscompares++;
            $display("FAIL capture_result: v=%b idx=%0d max=%0d margin=%0d expected 1 5 9 3",
                     out_valid, class_idx, max_score, margin);
        end
        tick(1);
        vectors++;
        if (frame_count !== 16'd2) begin
            miscompares++;
            $display("FAIL capture_fc: fc=%0d expected 2 (out_ready during scan ignored)", frame_count);
        end
    endtask

    task automatic test_back_to_back;
        int frames [3][10];
        int exp_idx [3];
        int exp_max [3];
        int exp_mrg [3];
        int prev = 0;
        frames[0] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        frames[1] = '{-1, -2, 50, 3, 49, 60, -100, 60, 0, 1};
        frames[2] = '{10, 20, 30, 40, 50, 60, 70, 80, 90, -20};
        exp_idx = '{0, 5, 8};
        exp_max = '{0, 60, 90};
        exp_mrg = '{0, 0, 10};
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
            load(frames[f]);
            tick(1);
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_accept%0d: in_ready=%b expected 0", f, in_ready);
            end
            if (f > 0) begin
                vectors++;
                if (cyc - prev != 11) begin
                    miscompares++;
                    $display("FAIL b2b_spacing%0d: %0d cycles expected 11", f, cyc - prev);
                end
            end
            prev = cyc;
            tick(9);
            vectors++;
            if (out_valid !== 1'b1 || class_idx !== 4'(exp_idx[f]) ||
                max_score !== 16'(exp_max[f]) || margin !== 16'(exp_mrg[f])) begin
                miscompares++;
                $display("FAIL b2b_result%0d: v=%b idx=%0d max=%0d margin=%0d expected 1 %0d %0d %0d",
                         f, out_valid, class_idx, max_score, margin, exp_idx[f], exp_max[f], exp_mrg[f]);
            end
            if (f == 2) in_valid = 1'b0;
            tick(1);
        end
        vectors++;
        if (frame_count !== 16'd3 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_fc: fc=%0d rdy=%b expected 3 1", frame_count, in_ready);
        end
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int j = 0; j < 10; j++) sc[j] = '0;
        test_reset;
        test_basic;
        test_extreme;
        test_stall;
        test_reset_mid;
        test_capture;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
